// File: rtl/nco_ctrl_pkg.sv
// Types shared by the NCO tuning controller, the NCO and the CSR bridge.
package nco_ctrl_pkg;

  localparam int NCO_W = 64;

  typedef logic [NCO_W-1:0] tuning_word_t;

  typedef enum logic {
    IDLE  = 1'b0,
    DWELL = 1'b1
  } ctrl_state_t;

endpackage

// File: rtl/nco_tune_ctrl.sv
// NCO phase-increment sequencer: single-shot CSR tune writes (priority) and a
// linear frequency sweep with programmable dwell, signed step and abort.
module nco_tune_ctrl #(
  parameter int NCO_W   = nco_ctrl_pkg::NCO_W,
  parameter int STEPS_W = 16,
  parameter int DWELL_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               csr_valid,
  output logic               csr_ready,
  input  logic [NCO_W-1:0]   csr_inc,
  input  logic               sweep_req,
  output logic               sweep_ack,
  input  logic [NCO_W-1:0]   sweep_start_inc,
  input  logic [NCO_W-1:0]   sweep_step_inc,
  input  logic [STEPS_W-1:0] sweep_steps,
  input  logic [DWELL_W-1:0] sweep_dwell,
  input  logic               sweep_abort,
  output logic               sweep_busy,
  output logic               sweep_done,
  output logic [NCO_W-1:0]   phase_inc_out,
  output logic               inc_update
);

  import nco_ctrl_pkg::ctrl_state_t;
  import nco_ctrl_pkg::IDLE;
  import nco_ctrl_pkg::DWELL;

  ctrl_state_t                state_q;
  logic        [NCO_W-1:0]    phase_inc_q;
  logic signed [NCO_W-1:0]    step_q;
  logic        [DWELL_W-1:0]  dwell_q;
  logic        [DWELL_W-1:0]  dwell_cnt_q;
  logic        [STEPS_W-1:0]  steps_left_q;
  logic                       inc_update_q;
  logic                       ack_q;
  logic                       busy_q;
  logic                       done_q;

  assign csr_ready     = (state_q == IDLE);
  assign phase_inc_out = phase_inc_q;
  assign inc_update    = inc_update_q;
  assign sweep_ack     = ack_q;
  assign sweep_busy    = busy_q;
  assign sweep_done    = done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      phase_inc_q  <= '0;
      step_q       <= '0;
      dwell_q      <= '0;
      dwell_cnt_q  <= '0;
      steps_left_q <= '0;
      inc_update_q <= 1'b0;
      ack_q        <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      inc_update_q <= 1'b0;
      ack_q        <= 1'b0;
      done_q       <= 1'b0;
      case (state_q)
        IDLE: begin
          // CSR wins a same-cycle collision; the sweep request stays pending.
          if (csr_valid) begin
            phase_inc_q  <= csr_inc;
            inc_update_q <= 1'b1;
          end else if (sweep_req) begin
            phase_inc_q  <= sweep_start_inc;
            step_q       <= signed'(sweep_step_inc);
            dwell_q      <= sweep_dwell;
            dwell_cnt_q  <= sweep_dwell;
            steps_left_q <= sweep_steps;
            inc_update_q <= 1'b1;
            ack_q        <= 1'b1;
            busy_q       <= 1'b1;
            state_q      <= DWELL;
          end
        end
        DWELL: begin
          if (sweep_abort) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else if (dwell_cnt_q != '0) begin
            dwell_cnt_q <= dwell_cnt_q - DWELL_W'(1);
          end else if (steps_left_q != '0) begin
            // Modular add: a negative step sweeps downward and may wrap.
            phase_inc_q  <= phase_inc_q + $unsigned(step_q);
            steps_left_q <= steps_left_q - STEPS_W'(1);
            dwell_cnt_q  <= dwell_q;
            inc_update_q <= 1'b1;
          end else begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nco_tune_ctrl.sv
// Directed bench for nco_tune_ctrl: CSR writes, sweep table, collision, abort, async reset.
module tb_nco_tune_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        csr_valid;
  logic        csr_ready;
  logic [63:0] csr_inc;
  logic        sweep_req;
  logic        sweep_ack;
  logic [63:0] sweep_start_inc;
  logic [63:0] sweep_step_inc;
  logic [15:0] sweep_steps;
  logic [31:0] sweep_dwell;
  logic        sweep_abort;
  logic        sweep_busy;
  logic        sweep_done;
  logic [63:0] phase_inc_out;
  logic        inc_update;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  nco_tune_ctrl dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .csr_valid       (csr_valid),
    .csr_ready       (csr_ready),
    .csr_inc         (csr_inc),
    .sweep_req       (sweep_req),
    .sweep_ack       (sweep_ack),
    .sweep_start_inc (sweep_start_inc),
    .sweep_step_inc  (sweep_step_inc),
    .sweep_steps     (sweep_steps),
    .sweep_dwell     (sweep_dwell),
    .sweep_abort     (sweep_abort),
    .sweep_busy      (sweep_busy),
    .sweep_done      (sweep_done),
    .phase_inc_out   (phase_inc_out),
    .inc_update      (inc_update)
  );

  typedef struct {
    logic [63:0] start;
    logic [63:0] step;
    logic [15:0] steps;
    logic [31:0] dwell;
    logic [63:0] final_inc;
    int          cycles;
  } sweep_vec_t;

  typedef struct {
    logic [63:0] inc;
  } csr_vec_t;

  sweep_vec_t swp_tbl[4];
  csr_vec_t   csr_tbl[3];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_sweep(input sweep_vec_t v);
    logic [63:0] exp_inc;
    int          per;
    per = int'(v.dwell) + 1;
    sweep_req       = 1'b1;
    sweep_start_inc = v.start;
    sweep_step_inc  = v.step;
    sweep_steps     = v.steps;
    sweep_dwell     = v.dwell;
    tick();
    chk("sweep_ack", 64'(sweep_ack), 64'd1);
    chk("sweep_busy_start", 64'(sweep_busy), 64'd1);
    chk("sweep_first_inc", phase_inc_out, v.start);
    chk("sweep_first_upd", 64'(inc_update), 64'd1);
    // Later input changes and CSR writes must not disturb the sweep.
    sweep_req       = 1'b0;
    sweep_start_inc = ~v.start;
    sweep_step_inc  = 64'h0BAD;
    sweep_steps     = 16'hFFFF;
    sweep_dwell     = 32'h7;
    csr_valid       = 1'b1;
    csr_inc         = 64'hDEAD_0000_0000_BEEF;
    for (int c = 1; c < v.cycles; c++) begin
      chk("csr_ready_busy", 64'(csr_ready), 64'd0);
      tick();
      exp_inc = v.start + v.step * 64'(c / per);
      chk("sweep_inc", phase_inc_out, exp_inc);
      chk("sweep_upd", 64'(inc_update), 64'((c % per) == 0));
      chk("sweep_busy", 64'(sweep_busy), 64'd1);
      chk("sweep_no_done", 64'(sweep_done), 64'd0);
      chk("sweep_no_ack", 64'(sweep_ack), 64'd0);
    end
    csr_valid = 1'b0;
    tick();
    chk("sweep_done", 64'(sweep_done), 64'd1);
    chk("sweep_busy_end", 64'(sweep_busy), 64'd0);
    chk("sweep_final_inc", phase_inc_out, v.final_inc);
    chk("sweep_final_upd", 64'(inc_update), 64'd0);
    tick();
    chk("sweep_done_pulse", 64'(sweep_done), 64'd0);
    chk("csr_ready_after", 64'(csr_ready), 64'd1);
  endtask

  initial begin
    csr_tbl[0] = '{inc: 64'h0100_0000_0000_0000};
    csr_tbl[1] = '{inc: 64'h0000_0000_0000_1234};
    csr_tbl[2] = '{inc: 64'hFFFF_FFFF_FFFF_FFFF};

    swp_tbl[0] = '{start: 64'h1000, step: 64'h10, steps: 16'd3, dwell: 32'd2,
                   final_inc: 64'h1030, cycles: 12};
    swp_tbl[1] = '{start: 64'h8, step: 64'hFFFF_FFFF_FFFF_FFFC, steps: 16'd3, dwell: 32'd0,
                   final_inc: 64'hFFFF_FFFF_FFFF_FFFC, cycles: 4};
    swp_tbl[2] = '{start: 64'hFFFF_FFFF_FFFF_FFFF, step: 64'h1, steps: 16'd1, dwell: 32'd1,
                   final_inc: 64'h0, cycles: 4};
    swp_tbl[3] = '{start: 64'h55, step: 64'h3, steps: 16'd0, dwell: 32'd0,
                   final_inc: 64'h55, cycles: 1};

    rst_n = 1'b0; csr_valid = 1'b0; csr_inc = '0; sweep_req = 1'b0;
    sweep_start_inc = '0; sweep_step_inc = '0; sweep_steps = '0; sweep_dwell = '0;
    sweep_abort = 1'b0;
    #2;
    chk("rst_phase", phase_inc_out, 64'd0);
    chk("rst_busy", 64'(sweep_busy), 64'd0);
    chk("rst_upd", 64'(inc_update), 64'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("rst_ready", 64'(csr_ready), 64'd1);
    chk("rst_done", 64'(sweep_done), 64'd0);
    chk("rst_ack", 64'(sweep_ack), 64'd0);

    // Back-to-back CSR writes.
    for (int i = 0; i < 3; i++) begin
      csr_valid = 1'b1;
      csr_inc   = csr_tbl[i].inc;
      tick();
      chk("csr_inc", phase_inc_out, csr_tbl[i].inc);
      chk("csr_upd", 64'(inc_update), 64'd1);
      chk("csr_ready", 64'(csr_ready), 64'd1);
    end
    csr_valid = 1'b0;
    csr_inc   = 64'h5;
    tick();
    chk("csr_upd_pulse", 64'(inc_update), 64'd0);
    chk("csr_hold", phase_inc_out, 64'hFFFF_FFFF_FFFF_FFFF);

    // Abort while idle does nothing.
    sweep_abort = 1'b1;
    tick();
    chk("idle_abort_busy", 64'(sweep_busy), 64'd0);
    chk("idle_abort_inc", phase_inc_out, 64'hFFFF_FFFF_FFFF_FFFF);
    sweep_abort = 1'b0;

    for (int i = 0; i < 4; i++) run_sweep(swp_tbl[i]);

    // CSR and sweep request collide: CSR first, sweep acked one cycle later.
    csr_valid = 1'b1; csr_inc = 64'hABC;
    sweep_req = 1'b1; sweep_start_inc = 64'h2000; sweep_step_inc = 64'h1;
    sweep_steps = 16'd0; sweep_dwell = 32'd0;
    tick();
    chk("coll_csr_inc", phase_inc_out, 64'hABC);
    chk("coll_no_ack", 64'(sweep_ack), 64'd0);
    chk("coll_not_busy", 64'(sweep_busy), 64'd0);
    csr_valid = 1'b0;
    tick();
    chk("coll_ack", 64'(sweep_ack), 64'd1);
    chk("coll_start", phase_inc_out, 64'h2000);
    sweep_req = 1'b0;
    tick();
    chk("coll_done", 64'(sweep_done), 64'd1);
    tick();

    // Abort in the second dwell cycle of the first stepped frequency.
    sweep_req = 1'b1; sweep_start_inc = 64'h100; sweep_step_inc = 64'h100;
    sweep_steps = 16'd3; sweep_dwell = 32'd2;
    tick();
    sweep_req = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("abort_pre_inc", phase_inc_out, 64'h200);
    sweep_abort = 1'b1;
    tick();
    sweep_abort = 1'b0;
    chk("abort_busy", 64'(sweep_busy), 64'd0);
    chk("abort_no_done", 64'(sweep_done), 64'd0);
    chk("abort_no_upd", 64'(inc_update), 64'd0);
    chk("abort_hold", phase_inc_out, 64'h200);
    chk("abort_ready", 64'(csr_ready), 64'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("abort_stays", {phase_inc_out[61:0], sweep_done, sweep_busy}, {62'h200, 2'b00});
    end

    // Asynchronous reset in the middle of a sweep.
    sweep_req = 1'b1; sweep_start_inc = 64'h500; sweep_step_inc = 64'h1;
    sweep_steps = 16'd5; sweep_dwell = 32'd3;
    tick();
    sweep_req = 1'b0;
    tick(); tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_phase", phase_inc_out, 64'd0);
    chk("arst_busy", 64'(sweep_busy), 64'd0);
    chk("arst_ack_upd", {62'd0, sweep_ack, inc_update}, 64'd0);
    tick();
    #3;
    rst_n = 1'b1;
    tick();
    chk("arst_ready", 64'(csr_ready), 64'd1);
    chk("arst_no_done", 64'(sweep_done), 64'd0);
    sweep_req = 1'b1; sweep_start_inc = 64'h777; sweep_steps = 16'd0; sweep_dwell = 32'd0;
    tick();
    sweep_req = 1'b0;
    chk("arst_new_ack", 64'(sweep_ack), 64'd1);
    chk("arst_new_inc", phase_inc_out, 64'h777);
    tick();
    chk("arst_new_done", 64'(sweep_done), 64'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
